elevator_ctrl_n: RTL
====================

ELEVATOR_CTRL_N -- requirements
Module: elevator_ctrl_n

Interface
REQ-001 SHALL provide parameter NUM_FLOORS, default 4, number of served floors (legal 2..16).
REQ-002 SHALL provide parameter TRAVEL_CYCLES, default 13, clock cycles per one-floor move (legal 2..255).
REQ-003 SHALL provide parameter DOOR_CYCLES, default 6, clock cycles door stays open (legal 2..255).
REQ-004 SHALL derive FW = clog2(NUM_FLOORS), minimum 1, as floor width.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 hall_up  input  NUM_FLOORS  hall up-call buttons; bit NUM_FLOORS-1 ignored.
REQ-008 hall_dn  input  NUM_FLOORS  hall down-call buttons; bit 0 ignored.
REQ-009 car_call  input  NUM_FLOORS  in-car floor buttons.
REQ-010 up_led, dn_led, car_led  output  NUM_FLOORS each  registered pending-request lamps.
REQ-011 opened  output  1  high while in OPEN.
REQ-012 direction  output  2  10 = moving up, 01 = moving down, 00 = IDLE or OPEN.
REQ-013 floor  output  FW  current floor index, 0 = lowest.

Function
REQ-014 SHALL implement states IDLE, MOVE_UP, MOVE_DN, OPEN plus internal sweep register dir_q (up/down), retained through OPEN.
REQ-015 SHALL latch any button press for floor f != floor (or any floor while moving) into its lamp on the next edge; lamps hold until served.
REQ-016 SHALL treat "pending at f" as car_led[f] | up_led[f] | dn_led[f]; "ahead" = pending above (dir_q up) or below (dir_q down) floor.
REQ-017 IDLE: pending or pressed at current floor -> OPEN next cycle, press not latched; else pending above -> MOVE_UP; else pending below -> MOVE_DN; up wins ties.
REQ-018 MOVE: travel counter increments each cycle from 0; at TRAVEL_CYCLES-1, floor +/-1 and counter returns to 0 on the same edge.
REQ-019 On arrival at floor f, SHALL enter OPEN if car_led[f], or hall lamp matching dir_q at f, or nothing ahead of f; else continue moving.
REQ-020 SHALL never move above NUM_FLOORS-1 or below 0; arrival at an end floor always opens.
REQ-021 On entering OPEN at f, SHALL clear car_led[f] and the hall lamp in dir_q; if nothing ahead, also clear the opposite hall lamp and flip dir_q.
REQ-022 A press at f in the arrival edge for the cleared lamp SHALL be absorbed (clear wins).
REQ-023 During OPEN, presses at current floor matching dir_q SHALL be absorbed; other presses latch normally.
REQ-024 OPEN lasts exactly DOOR_CYCLES cycles, then: pending ahead -> move in dir_q; else pending behind -> move opposite, update dir_q; else IDLE.
REQ-025 Outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Reset
REQ-026 On rst_n=0 at a clock edge: state IDLE, dir_q up, floor 0, counters 0, all lamps 0, opened 0, direction 00.
REQ-027 Reset mid-move or mid-open SHALL discard all pending requests and return car to floor 0 immediately.

Configuration
REQ-028 Macro DOOR_HOLD_EN SHALL, when defined, add input door_hold (1 bit): in OPEN, door_hold=1 reloads door counter to 0, extending OPEN until released plus DOOR_CYCLES.
REQ-029 Without DOOR_HOLD_EN, no door_hold port exists and OPEN length is fixed at DOOR_CYCLES.

Verification
REQ-030 Reset with buttons active -> floor=0, direction=00, opened=0, all lamps 0 for every cycle rst_n=0.
REQ-031 Defaults, IDLE floor 0, car_call[2] one-cycle pulse -> car_led[2]=1 next cycle, direction=10, floor=1 after 13 cycles, floor=2 after 26, opened=1 for 6 cycles, car_led[2]=0.
REQ-032 Moving up from 0 toward car_call[3], hall_dn[1] pressed at cycle 5 -> no stop at 1 going up; opens at 3, then moves down and opens at 1, dn_led[1] cleared.
REQ-033 IDLE floor 0, hall_up[0] pressed -> opened=1 next cycle for 6 cycles, up_led[0] never set.
REQ-034 NUM_FLOORS=8, car_call[7] from floor 0 -> floor=7 after 91 cycles, never exceeds 7, then IDLE after 6 open cycles.
REQ-035 DOOR_HOLD_EN defined, door_hold high 10 cycles from OPEN entry -> opened=1 for 16 cycles total.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : elevator_ctrl_n
// Purpose  : Single-car collective elevator controller with request lamps.
//            Define DOOR_HOLD_EN to add the door_hold input.
// Revision : 1.0
// ============================================================================
module elevator_ctrl_n #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 13,
  parameter int DOOR_CYCLES   = 6,
  localparam int FW = ($clog2(NUM_FLOORS) > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic [NUM_FLOORS-1:0] car_call,
  output logic [NUM_FLOORS-1:0] up_led,
  output logic [NUM_FLOORS-1:0] dn_led,
  output logic [NUM_FLOORS-1:0] car_led,
  output logic                  opened,
  output logic [1:0]            direction,
  output logic [FW-1:0]         floor
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MOVE_UP = 2'd1,
    S_MOVE_DN = 2'd2,
    S_OPEN    = 2'd3
  } state_t;

  localparam logic [NUM_FLOORS-1:0] c_up_valid    = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] c_dn_valid    = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [NUM_FLOORS-1:0] c_one         = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
  localparam logic [7:0]            c_travel_last = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0]            c_door_last   = 8'(DOOR_CYCLES - 1);

  state_t     r_state;
  logic       r_dir_up;
  logic [7:0] r_tcnt;
  logic [7:0] r_dcnt;

  function automatic logic any_beyond(input logic [NUM_FLOORS-1:0] m,
                                      input logic [FW-1:0] f, input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (up ? (i > int'(f)) : (i < int'(f))) r = r | m[i];
    return r;
  endfunction

  logic                  w_hold;
  logic [NUM_FLOORS-1:0] w_hup, w_hdn, w_press, w_pend, w_here, w_open_oh;
  logic [NUM_FLOORS-1:0] w_set_car, w_set_up, w_set_dn;
  logic [NUM_FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn;
  logic                  w_moving, w_arrive, w_stop, w_idle_open, w_enter_open;
  logic                  w_open_ahead, w_above_here, w_below_here, w_ahead_here;
  logic                  w_any_else, w_go_up;
  logic [FW-1:0]         w_next_floor, w_open_floor;

`ifdef DOOR_HOLD_EN
  assign w_hold = door_hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_hup    = hall_up & c_up_valid;
  assign w_hdn    = hall_dn & c_dn_valid;
  assign w_press  = car_call | w_hup | w_hdn;
  assign w_pend   = car_led | up_led | dn_led;
  assign w_here   = c_one << floor;

  assign w_moving     = (r_state == S_MOVE_UP) || (r_state == S_MOVE_DN);
  assign w_arrive     = w_moving && (r_tcnt == c_travel_last);
  assign w_next_floor = (r_state == S_MOVE_UP) ? floor + FW'(1) : floor - FW'(1);
  // End floors always stop because nothing can be pending beyond them.
  assign w_stop       = car_led[w_next_floor] |
                        (r_dir_up ? up_led[w_next_floor] : dn_led[w_next_floor]) |
                        ~any_beyond(w_pend, w_next_floor, r_dir_up);
  assign w_idle_open  = (r_state == S_IDLE) && (w_pend[floor] | w_press[floor]);
  assign w_enter_open = w_idle_open | (w_arrive & w_stop);
  assign w_open_floor = w_idle_open ? floor : w_next_floor;
  assign w_open_oh    = c_one << w_open_floor;
  assign w_open_ahead = any_beyond(w_pend, w_open_floor, r_dir_up);

  assign w_clr_car = w_enter_open ? w_open_oh : '0;
  assign w_clr_up  = (w_enter_open && (r_dir_up || !w_open_ahead)) ? w_open_oh : '0;
  assign w_clr_dn  = (w_enter_open && (!r_dir_up || !w_open_ahead)) ? w_open_oh : '0;

  assign w_above_here = any_beyond(w_pend, floor, 1'b1);
  assign w_below_here = any_beyond(w_pend, floor, 1'b0);
  assign w_ahead_here = r_dir_up ? w_above_here : w_below_here;
  assign w_any_else   = w_above_here | w_below_here;
  assign w_go_up      = (r_state == S_IDLE) ? w_above_here
                                            : (w_ahead_here ? r_dir_up : ~r_dir_up);

  always_comb begin
    w_set_car = car_call;
    w_set_up  = w_hup;
    w_set_dn  = w_hdn;
    case (r_state)
      S_IDLE: begin
        w_set_car = car_call & ~w_here;
        w_set_up  = w_hup & ~w_here;
        w_set_dn  = w_hdn & ~w_here;
      end
      S_OPEN: begin
        // The opposite-direction hall call at this floor still needs service later.
        w_set_car = car_call & ~w_here;
        if (r_dir_up) w_set_up = w_hup & ~w_here;
        else          w_set_dn = w_hdn & ~w_here;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dir_up  <= 1'b1;
      r_tcnt    <= 8'd0;
      r_dcnt    <= 8'd0;
      floor     <= '0;
      up_led    <= '0;
      dn_led    <= '0;
      car_led   <= '0;
      opened    <= 1'b0;
      direction <= 2'b00;
    end else begin
      car_led <= (car_led | w_set_car) & ~w_clr_car;
      up_led  <= (up_led  | w_set_up)  & ~w_clr_up;
      dn_led  <= (dn_led  | w_set_dn)  & ~w_clr_dn;
      r_tcnt  <= (w_moving && !w_arrive) ? r_tcnt + 8'd1 : 8'd0;
      if (w_arrive) floor <= w_next_floor;

      if (w_enter_open) begin
        r_state   <= S_OPEN;
        opened    <= 1'b1;
        direction <= 2'b00;
        r_dcnt    <= 8'd0;
        if (!w_open_ahead) r_dir_up <= ~r_dir_up;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_any_else) begin
              r_dir_up  <= w_go_up;
              r_state   <= w_go_up ? S_MOVE_UP : S_MOVE_DN;
              direction <= w_go_up ? 2'b10 : 2'b01;
            end
          end
          S_OPEN: begin
            if (w_hold) begin
              r_dcnt <= 8'd0;
            end else if (r_dcnt != c_door_last) begin
              r_dcnt <= r_dcnt + 8'd1;
            end else begin
              r_dcnt <= 8'd0;
              opened <= 1'b0;
              if (w_any_else) begin
                r_dir_up  <= w_go_up;
                r_state   <= w_go_up ? S_MOVE_UP : S_MOVE_DN;
                direction <= w_go_up ? 2'b10 : 2'b01;
              end else begin
                r_state   <= S_IDLE;
                direction <= 2'b00;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
